instr_prefetch: RTL
===================

Name: instr_prefetch

Overview:
- Upstream neighbour of the sequential fetch stage. Walks a byte-wide synchronous instruction ROM starting from a programmed PC.
- Decodes the instruction length from the icode byte and assembles one complete Y86-64 instruction, 1 to 10 bytes, into an 80-bit window.
- Hands that window plus its PC to fetch over a valid/ready handshake, then advances PC by the length.
- Supports PC redirect (jump/call/ret target), stops after a delivered halt, and flags address and invalid-icode errors.

Parameters:
IMEM_AW, 8, instruction ROM address width; top address is 2^IMEM_AW-1.
RESET_PC, 64'd1, PC loaded at reset.

Ports:
clk  in  1  clock; all state on posedge.
rst_n  in  1  synchronous active-low reset.
imem_addr  out  IMEM_AW  ROM byte address.
imem_rdata  in  8  ROM data; valid in the cycle after imem_addr is presented.
redirect_valid  in  1  load redirect_pc as the new fetch PC.
redirect_pc  in  64  redirect target.
instr_window  out  80  instruction bytes; byte0 (icode:ifun) in bits [79:72], byte k in bits [79-8k:72-8k]; bytes at or beyond instr_len are zero.
instr_pc  out  64  PC of the delivered instruction.
instr_len  out  4  length, 1..10.
instr_valid  out  1  window valid.
instr_ready  in  1  fetch accepts the window.
ins_err  out  1  delivered icode is invalid (>4'hB).
pc_err  out  1  sticky address error.
halted  out  1  sticky; a halt instruction was accepted.

Behaviour:
- Reset (rst_n=0 at posedge): PC=RESET_PC, state=FETCH, byte counter=0.
  - All outputs are 0 except imem_addr, which is RESET_PC[IMEM_AW-1:0].
  - A reset asserted mid-fetch or mid-HOLD discards everything.
- States: FETCH, HOLD, STOP, ERR.
- Length table by icode:
  - 0, 1, 9 -> 1
  - 2, 6, A, B -> 2
  - 7, 8 -> 9
  - 3, 4, 5 -> 10
  - Any other icode -> length 1 with ins_err=1.
- FETCH:
  - Timing: t0 is the first FETCH cycle for an instruction.
  - In cycle t0+i, imem_addr = PC+i. The returned byte is captured at the end of cycle t0+i+1.
  - Length is known once byte0 is captured. Addresses issued past the length are speculative, and their data is ignored.
  - After the last byte (index len-1) is captured, go to HOLD. instr_valid=1 from cycle t0+len+1.
  - Latency: 1-byte instruction valid 2 cycles after t0; 10-byte instruction valid 11 cycles after t0.
- HOLD:
  - instr_window, instr_pc, instr_len and ins_err are held stable while instr_valid=1 and instr_ready=0.
  - On instr_valid & instr_ready: PC <= PC+instr_len (64-bit, wraps modulo 2^64). Next state is FETCH, or STOP if icode was 0.
  - No bubble beyond the fetch latency: the next instruction's t0 is the cycle after acceptance.
- STOP: halted=1, instr_valid=0. Only redirect_valid or reset exits.
- Redirect:
  - redirect_valid in any state except ERR: PC <= redirect_pc, byte counter <= 0, next state FETCH, halted <= 0.
  - Any partial or held instruction is dropped. instr_valid drops the next cycle.
  - A ROM byte returning in the cycle after a redirect belongs to the old PC and is discarded.
  - Redirect has priority over a simultaneous accept. The accepted instruction still counts as consumed by fetch, but PC follows redirect_pc.
- Address error:
  - Triggered when byte0 is captured and PC+len-1 > 2^IMEM_AW-1, or when PC itself exceeds the top address.
  - Effect: go to ERR with pc_err=1 and instr_valid=0; the instruction is not delivered.
  - Speculative addresses past the length never cause an error. imem_addr saturates at the top address and is don't-care.
- ERR: sticky; only reset exits. Redirect is ignored.
- ins_err is delivered with the instruction. The block continues at PC+1; the downstream status logic decides whether to stop.

Test Plan:
- Reset, ROM[1]=8'h10, ROM[2..3]=20 12, ready=1 -> nop delivered with len=1, pc=1, window[79:72]=8'h10, rest 0, valid 2 cycles after reset release; then rrmovq pc=2, len=2, window[79:64]=16'h2012.
- irmovq at PC=4, bytes 30 F2 00..00 02, instr_ready held low 5 cycles -> valid at t0+11, len=10, window stable throughout the stall; after accept, PC=14.
- jXX 73 + 8 bytes of 56 at PC=46, then redirect_valid with redirect_pc=56 asserted together with accept -> next delivered pc=56, not 55.
- ROM[55]=8'h00 at PC=55 accepted -> halted=1, instr_valid stays 0 for 20 cycles; then redirect to 1 -> halted=0 and nop re-delivered.
- IMEM_AW=8, PC=250, icode 3 (len 10) -> pc_err=1, no valid. PC=255 with nop -> delivered, no error.
- Byte 8'hC0 at PC=5 -> ins_err=1, len=1, next pc=6. Reset asserted while a 10-byte fetch is at byte 4 -> all outputs 0, restart at PC=1.

Source files
------------

// File: rtl/instr_prefetch_if.sv
// Prefetch-side bus: byte ROM port, redirect request, and the instruction
// window handshake towards the fetch stage.
interface instr_prefetch_if #(
    parameter int IMEM_AW = 8
);
    logic [IMEM_AW-1:0] imem_addr;
    logic [7:0]         imem_rdata;
    logic               redirect_valid;
    logic [63:0]        redirect_pc;
    logic [79:0]        instr_window;
    logic [63:0]        instr_pc;
    logic [3:0]         instr_len;
    logic               instr_valid;
    logic               instr_ready;
    logic               ins_err;
    logic               pc_err;
    logic               halted;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output instr_window,
        output instr_pc,
        output instr_len,
        output instr_valid,
        input  instr_ready,
        output ins_err,
        output pc_err,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  instr_window,
        input  instr_pc,
        input  instr_len,
        input  instr_valid,
        output instr_ready,
        input  ins_err,
        input  pc_err,
        input  halted
    );
endinterface

// File: rtl/instr_prefetch.sv
// Walks a byte-wide synchronous ROM, assembles one Y86-64 instruction (1..10
// bytes) into an 80-bit window and hands it to fetch over valid/ready.
module instr_prefetch #(
    parameter int          IMEM_AW  = 8,
    parameter logic [63:0] RESET_PC = 64'd1
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_prefetch_if.master bus
);
    localparam logic [64:0] TOP = (65'd1 << IMEM_AW) - 65'd1;

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_STOP, S_ERR} state_t;

    state_t      state_reg;
    logic [63:0] pc_reg;
    logic [3:0]  iss_reg;       // cycles spent in FETCH; byte iss_reg-1 is on imem_rdata
    logic [79:0] win_reg;
    logic [3:0]  len_reg;
    logic [63:0] ipc_reg;
    logic        valid_reg;
    logic        ins_err_reg;
    logic        pc_err_reg;
    logic        halted_reg;

    function automatic logic [3:0] len_of(input logic [3:0] icode);
        case (icode)
            4'h0, 4'h1, 4'h9:       len_of = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: len_of = 4'd2;
            4'h7, 4'h8:             len_of = 4'd9;
            4'h3, 4'h4, 4'h5:       len_of = 4'd10;
            default:                len_of = 4'd1;
        endcase
    endfunction

    logic [64:0] addr_sum;
    logic [3:0]  b0_len;
    logic [64:0] b0_end;
    logic        b0_bad;

    // Speculative addresses may run past the ROM; clamp instead of wrapping.
    assign addr_sum = {1'b0, pc_reg} + {61'd0, iss_reg};
    assign bus.imem_addr = (addr_sum > TOP) ? TOP[IMEM_AW-1:0] : addr_sum[IMEM_AW-1:0];

    assign b0_len = len_of(bus.imem_rdata[7:4]);
    assign b0_end = {1'b0, pc_reg} + {61'd0, b0_len} - 65'd1;
    assign b0_bad = ({1'b0, pc_reg} > TOP) || (b0_end > TOP);

    assign bus.instr_window = win_reg;
    assign bus.instr_pc     = ipc_reg;
    assign bus.instr_len    = len_reg;
    assign bus.instr_valid  = valid_reg;
    assign bus.ins_err      = ins_err_reg;
    assign bus.pc_err       = pc_err_reg;
    assign bus.halted       = halted_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_FETCH;
            pc_reg      <= RESET_PC;
            iss_reg     <= 4'd0;
            win_reg     <= 80'd0;
            len_reg     <= 4'd0;
            ipc_reg     <= 64'd0;
            valid_reg   <= 1'b0;
            ins_err_reg <= 1'b0;
            pc_err_reg  <= 1'b0;
            halted_reg  <= 1'b0;
        end else if (bus.redirect_valid && state_reg != S_ERR) begin
            // Clearing iss_reg also discards the stale byte arriving next cycle.
            state_reg  <= S_FETCH;
            pc_reg     <= bus.redirect_pc;
            iss_reg    <= 4'd0;
            valid_reg  <= 1'b0;
            halted_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    iss_reg <= iss_reg + 4'd1;
                    if (iss_reg == 4'd1) begin
                        if (b0_bad) begin
                            state_reg  <= S_ERR;
                            pc_err_reg <= 1'b1;
                        end else begin
                            win_reg     <= {bus.imem_rdata, 72'd0};
                            len_reg     <= b0_len;
                            ipc_reg     <= pc_reg;
                            ins_err_reg <= (bus.imem_rdata[7:4] > 4'hB);
                            if (b0_len == 4'd1) begin
                                state_reg <= S_HOLD;
                                valid_reg <= 1'b1;
                            end
                        end
                    end else if (iss_reg >= 4'd2) begin
                        for (int k = 1; k < 10; k++) begin
                            if (iss_reg == 4'(k + 1))
                                win_reg[79 - 8*k -: 8] <= bus.imem_rdata;
                        end
                        if (iss_reg == len_reg) begin
                            state_reg <= S_HOLD;
                            valid_reg <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.instr_ready) begin
                        pc_reg    <= pc_reg + {60'd0, len_reg};
                        iss_reg   <= 4'd0;
                        valid_reg <= 1'b0;
                        if (win_reg[79:76] == 4'h0) begin
                            state_reg  <= S_STOP;
                            halted_reg <= 1'b1;
                        end else begin
                            state_reg <= S_FETCH;
                        end
                    end
                end
                default: begin
                    // STOP waits for redirect, ERR waits for reset.
                end
            endcase
        end
    end
endmodule
